// File: rtl/tangram_calc_unit_pkg.sv
// Shared constants and helpers for the tangram calculator unit.
package tangram_calc_unit_pkg;

  // Colour width: 4 bits each for R, G, B
  localparam int PIXLW        = 12;
  // Palette is a square of PAL_SIZE x PAL_SIZE positions
  localparam int PAL_SIZE     = 128;
  localparam int PAL_COORDW   = $clog2(PAL_SIZE);
  // Default legal angle range, inclusive, in degrees
  localparam int DEF_DW_BOUND = -180;
  localparam int DEF_UP_BOUND = 179;
  // Decimal splitter geometry
  localparam int NUM_DIGITS   = 5;
  localparam int DIGITW       = 4;

  // Palette colour at (px,py): red ramps with x, green with y, blue falls with x
  function automatic logic [PIXLW-1:0] palette_color(input logic [PAL_COORDW-1:0] px,
                                                     input logic [PAL_COORDW-1:0] py);
    logic [3:0] r;
    logic [3:0] g;
    r = px[PAL_COORDW-1 -: 4];
    g = py[PAL_COORDW-1 -: 4];
    return {r, g, 4'd15 - r};
  endfunction

endpackage

// File: rtl/tangram_calc_unit_div10_stage.sv
// One divide-by-10 step of the decimal splitter: exact quotient and remainder.
module div10_stage
  import tangram_calc_unit_pkg::*;
#(
  parameter int DATAW = 16
) (
  input  logic [DATAW-1:0]  dividend,
  output logic [DATAW-1:0]  quotient,
  output logic [DIGITW-1:0] remainder
);

  // Division by a constant is exact and synthesises to fixed arithmetic;
  // the remainder is always 0..9, so the low digit bits hold it completely.
  assign quotient  = dividend / DATAW'(10);
  assign remainder = DIGITW'(dividend - quotient * DATAW'(10));

endmodule

// File: rtl/tangram_calc_unit.sv
// Tangram helper datapath: circular angle step, palette colour lookup with
// cursor crosshair, and a five-digit decimal splitter. All outputs registered.
module tangram_calc_unit #(
  parameter int DATAW    = 16,
  parameter int DW_BOUND = tangram_calc_unit_pkg::DEF_DW_BOUND,
  parameter int UP_BOUND = tangram_calc_unit_pkg::DEF_UP_BOUND,
  parameter int PIXLW    = tangram_calc_unit_pkg::PIXLW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [DATAW-1:0] angle_in,
  output logic signed [DATAW-1:0] angle_prev,
  output logic signed [DATAW-1:0] angle_next,
  input  logic [6:0]              cur_x,
  input  logic [6:0]              cur_y,
  input  logic [6:0]              pix_x,
  input  logic [6:0]              pix_y,
  output logic [PIXLW-1:0]        pick_color,
  output logic [PIXLW-1:0]        pal_render,
  input  logic [DATAW-1:0]        dec_in,
  output logic [19:0]             dec_digits
);
  import tangram_calc_unit_pkg::*;

  localparam logic signed [DATAW-1:0] LO_ANGLE = DATAW'(DW_BOUND);
  localparam logic signed [DATAW-1:0] HI_ANGLE = DATAW'(UP_BOUND);

  logic signed [DATAW-1:0] angle_prev_next;
  logic signed [DATAW-1:0] angle_next_next;
  logic [PIXLW-1:0]        pick_color_next;
  logic [PIXLW-1:0]        pal_color;
  logic [PIXLW-1:0]        pal_render_next;
  logic [19:0]             dec_digits_next;
  logic [DATAW-1:0]        div_chain [0:NUM_DIGITS];

  // Angle step: wrap only at the exact bounds; anything out of range just steps
  always_comb begin
    angle_next_next = angle_in + DATAW'(1);
    angle_prev_next = angle_in - DATAW'(1);
    if (angle_in == HI_ANGLE) angle_next_next = LO_ANGLE;
    if (angle_in == LO_ANGLE) angle_prev_next = HI_ANGLE;
  end

  // Palette lookups; the crosshair inverts every pixel on the cursor row or column
  assign pick_color_next = PIXLW'(palette_color(cur_x, cur_y));
  assign pal_color       = PIXLW'(palette_color(pix_x, pix_y));
  assign pal_render_next = ((pix_x == cur_x) || (pix_y == cur_y)) ? ~pal_color : pal_color;

  // Decimal splitter: each stage's quotient feeds the next, remainder is one digit
  assign div_chain[0] = dec_in;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      div10_stage #(
        .DATAW (DATAW)
      ) u_div10 (
        .dividend  (div_chain[gi]),
        .quotient  (div_chain[gi+1]),
        .remainder (dec_digits_next[gi*DIGITW +: DIGITW])
      );
    end
  endgenerate

  // Output registers; the top quotient is always zero for 16-bit inputs and is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle_prev <= '0;
      angle_next <= '0;
      pick_color <= '0;
      pal_render <= '0;
      dec_digits <= '0;
    end else begin
      angle_prev <= angle_prev_next;
      angle_next <= angle_next_next;
      pick_color <= pick_color_next;
      pal_render <= pal_render_next;
      dec_digits <= dec_digits_next;
    end
  end

  logic unused_top_quotient;
  assign unused_top_quotient = ^div_chain[NUM_DIGITS];

endmodule

// File: tb/tb_tangram_calc_unit.sv
// Scoreboard bench for tangram_calc_unit plus exhaustive div10_stage sweep.
module tb_tangram_calc_unit;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] angle_in;
  logic signed [15:0] angle_prev;
  logic signed [15:0] angle_next;
  logic [6:0]         cur_x, cur_y, pix_x, pix_y;
  logic [11:0]        pick_color, pal_render;
  logic [15:0]        dec_in;
  logic [19:0]        dec_digits;

  logic [15:0]        div_in;
  logic [15:0]        div_q;
  logic [3:0]         div_r;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int                 idx;
    logic signed [15:0] angle;
    logic [6:0]         cx, cy, px, py;
    logic [15:0]        dec;
    logic signed [15:0] prev, next;
    logic [11:0]        pick, render;
    logic [19:0]        digits;
  } vec_t;

  vec_t vecs [0:6];
  vec_t exp_q [$];
  logic stim_valid = 1'b0;

  tangram_calc_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .angle_in   (angle_in),
    .angle_prev (angle_prev),
    .angle_next (angle_next),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pick_color (pick_color),
    .pal_render (pal_render),
    .dec_in     (dec_in),
    .dec_digits (dec_digits)
  );

  div10_stage #(.DATAW(16)) u_div_sweep (
    .dividend  (div_in),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_angle_prev"}, angle_prev, 0);
    check({tag, "_angle_next"}, angle_next, 0);
    check({tag, "_pick_color"}, pick_color, 0);
    check({tag, "_pal_render"}, pal_render, 0);
    check({tag, "_dec_digits"}, dec_digits, 0);
  endtask

  function automatic vec_t mk(input int idx, input logic signed [15:0] a,
                              input logic [6:0] cx, input logic [6:0] cy,
                              input logic [6:0] px, input logic [6:0] py,
                              input logic [15:0] d,
                              input logic signed [15:0] pv, input logic signed [15:0] nx,
                              input logic [11:0] pk, input logic [11:0] rd,
                              input logic [19:0] dg);
    vec_t v;
    v.idx = idx; v.angle = a; v.cx = cx; v.cy = cy; v.px = px; v.py = py; v.dec = d;
    v.prev = pv; v.next = nx; v.pick = pk; v.render = rd; v.digits = dg;
    return v;
  endfunction

  // Drive one vector right after a rising edge and record what must appear a cycle later
  task automatic issue(input vec_t v);
    @(posedge clk);
    #1;
    angle_in = v.angle;
    cur_x = v.cx; cur_y = v.cy; pix_x = v.px; pix_y = v.py;
    dec_in = v.dec;
    exp_q.push_back(v);
    stim_valid = 1'b1;
    $display("issue vec %0d: angle=%0d cur=(%0d,%0d) pix=(%0d,%0d) dec=%0d",
             v.idx, v.angle, v.cx, v.cy, v.px, v.py, v.dec);
  endtask

  // Monitor: a vector captured at a rising edge is compared on the following falling edge
  initial begin
    logic v;
    vec_t e;
    forever begin
      @(posedge clk);
      v = stim_valid;
      @(negedge clk);
      if (v && rst_n) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("v%0d_angle_prev", e.idx), angle_prev, e.prev);
          check($sformatf("v%0d_angle_next", e.idx), angle_next, e.next);
          check($sformatf("v%0d_pick_color", e.idx), pick_color, e.pick);
          check($sformatf("v%0d_pal_render", e.idx), pal_render, e.render);
          check($sformatf("v%0d_dec_digits", e.idx), dec_digits, e.digits);
          $display("result vec %0d: prev=%0d next=%0d pick=%h render=%h digits=%h",
                   e.idx, angle_prev, angle_next, pick_color, pal_render, dec_digits);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    int bad;
    int first_bad;
    //            idx angle    cx   cy   px   py   dec     prev     next    pick    render  digits
    vecs[0] = mk(0,  179,     127, 0,   0,   0,   0,      178,     -180,   12'hF00, 12'hFF0, 20'h00000);
    vecs[1] = mk(1,  0,       8,   8,   8,   100, 9,      -1,      1,      12'h11E, 12'hE31, 20'h00009);
    vecs[2] = mk(2,  -180,    8,   8,   9,   9,   10,     179,     -179,   12'h11E, 12'h11E, 20'h00010);
    vecs[3] = mk(3,  200,     64,  127, 120, 50,  359,    199,     201,    12'h8F7, 12'hF60, 20'h00359);
    vecs[4] = mk(4,  -32768,  0,   127, 33,  127, 65535,  32767,   -32767, 12'h0FF, 12'hB04, 20'h65535);
    vecs[5] = mk(5,  -179,    127, 127, 127, 5,   12345,  -180,    -178,   12'hFF0, 12'h0FF, 20'h12345);
    vecs[6] = mk(6,  178,     1,   2,   3,   4,   100,    177,     179,    12'h00F, 12'h00F, 20'h00100);

    rst_n = 1'b0;
    angle_in = '0; cur_x = '0; cur_y = '0; pix_x = '0; pix_y = '0; dec_in = '0;
    div_in = '0;
    #3;
    check_zero("reset_initial");
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) issue(vecs[i]);
    issue(vecs[3]);
    issue(vecs[4]);

    // Reset mid-stream: vec 4 is pending and must be discarded
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    stim_valid = 1'b0;
    exp_q.delete();
    #1;
    check_zero("reset_async");
    @(negedge clk);
    check_zero("reset_held");
    #2;
    rst_n = 1'b1;

    issue(vecs[5]);
    issue(vecs[6]);
    issue(vecs[0]);
    @(posedge clk);
    #1;
    stim_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    // Exhaustive sweep of the divide-by-10 stage
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < 65536; i++) begin
      div_in = 16'(i);
      #1;
      if ((32'(div_q) * 10 + 32'(div_r)) != i || div_r >= 4'd10) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
    end
    if (first_bad >= 0) $display("div10 sweep: first wrong input %0d", first_bad);
    check("div10_exhaustive_errors", bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
